// File: rtl/excess3_deserializer.sv
`default_nettype none
// ============================================================================
//  Module   : excess3_deserializer
//  Purpose  : Frames the serial excess-3 stream (LSB first, 4 bits per digit)
//             into parallel digits, flags illegal codes or converter overflow,
//             and packs NDIGITS consecutive digits into one parallel word.
//  Revision : 1.0 - initial release
// ============================================================================
module excess3_deserializer #(
  parameter int NDIGITS = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   s_in,
  input  logic                   v_in,
  output logic [3:0]             digit,
  output logic                   digit_valid,
  output logic                   digit_err,
  output logic [4*NDIGITS-1:0]   word,
  output logic                   word_valid,
  output logic                   word_err
);

  localparam int c_word_w = 4 * NDIGITS;
  localparam int c_cnt_w  = $clog2(NDIGITS);

  // Framing state
  logic [1:0]          phase_q,   phase_d;
  logic [3:0]          shreg_q,   shreg_d;
  logic [3:0]          hold_q,    hold_d;
  logic                pending_q, pending_d;

  // Word assembly state
  logic [c_cnt_w-1:0]  cnt_q,     cnt_d;
  logic [c_word_w-1:0] acc_q,     acc_d;
  logic                err_acc_q, err_acc_d;

  // Registered outputs
  logic [3:0]          digit_q,       digit_d;
  logic                digit_valid_q, digit_valid_d;
  logic                digit_err_q,   digit_err_d;
  logic [c_word_w-1:0] word_q,        word_d;
  logic                word_valid_q,  word_valid_d;
  logic                word_err_q,    word_err_d;

  // A digit is released on the phase-0 edge that follows its bit 3.
  logic                w_event;
  logic                w_new_err;
  logic [c_word_w-1:0] w_acc_shift;

  assign w_event     = pending_q && (phase_q == 2'd0);
  // v_in only carries meaning in the cycle a digit is being released.
  assign w_new_err   = v_in || (hold_q < 4'd3) || (hold_q > 4'd12);
  assign w_acc_shift = {hold_q, acc_q[c_word_w-1:4]};

  // Next-state logic: bit framing, digit release and word packing.
  always_comb begin
    phase_d       = phase_q + 2'd1;
    shreg_d       = {s_in, shreg_q[3:1]};
    hold_d        = hold_q;
    pending_d     = pending_q;
    cnt_d         = cnt_q;
    acc_d         = acc_q;
    err_acc_d     = err_acc_q;
    digit_d       = digit_q;
    digit_valid_d = 1'b0;
    digit_err_d   = digit_err_q;
    word_d        = word_q;
    word_valid_d  = 1'b0;
    word_err_d    = word_err_q;

    // Bit 3 arrives: capture the whole code so the shifter can keep going.
    if (phase_q == 2'd3) begin
      hold_d    = {s_in, shreg_q[3:1]};
      pending_d = 1'b1;
    end

    if (w_event) begin
      pending_d     = 1'b0;
      digit_d       = hold_q;
      digit_valid_d = 1'b1;
      digit_err_d   = w_new_err;
      if (cnt_q == c_cnt_w'(NDIGITS - 1)) begin
        // Last digit of the word: publish and restart the accumulator.
        word_d       = w_acc_shift;
        word_err_d   = err_acc_q || w_new_err;
        word_valid_d = 1'b1;
        cnt_d        = '0;
        acc_d        = '0;
        err_acc_d    = 1'b0;
      end else begin
        acc_d     = w_acc_shift;
        err_acc_d = err_acc_q || w_new_err;
        cnt_d     = cnt_q + c_cnt_w'(1);
      end
    end
  end

  // State register with synchronous reset discarding any partial digit/word.
  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q       <= '0;
      shreg_q       <= '0;
      hold_q        <= '0;
      pending_q     <= 1'b0;
      cnt_q         <= '0;
      acc_q         <= '0;
      err_acc_q     <= 1'b0;
      digit_q       <= '0;
      digit_valid_q <= 1'b0;
      digit_err_q   <= 1'b0;
      word_q        <= '0;
      word_valid_q  <= 1'b0;
      word_err_q    <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      shreg_q       <= shreg_d;
      hold_q        <= hold_d;
      pending_q     <= pending_d;
      cnt_q         <= cnt_d;
      acc_q         <= acc_d;
      err_acc_q     <= err_acc_d;
      digit_q       <= digit_d;
      digit_valid_q <= digit_valid_d;
      digit_err_q   <= digit_err_d;
      word_q        <= word_d;
      word_valid_q  <= word_valid_d;
      word_err_q    <= word_err_d;
    end
  end

  assign digit       = digit_q;
  assign digit_valid = digit_valid_q;
  assign digit_err   = digit_err_q;
  assign word        = word_q;
  assign word_valid  = word_valid_q;
  assign word_err    = word_err_q;

endmodule
`default_nettype wire

// File: tb/tb_excess3_deserializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_excess3_deserializer
//  Purpose  : Self-checking bench for excess3_deserializer (NDIGITS = 4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_excess3_deserializer;

  localparam int NDIG = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              s_in = 1'b0;
  logic              v_in = 1'b0;
  logic [3:0]        digit;
  logic              digit_valid;
  logic              digit_err;
  logic [4*NDIG-1:0] word;
  logic              word_valid;
  logic              word_err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] codes [0:63];
  logic       vs    [0:63];

  excess3_deserializer #(.NDIGITS(NDIG)) dut (
    .clock       (clk),
    .reset       (rst),
    .s_in        (s_in),
    .v_in        (v_in),
    .digit       (digit),
    .digit_valid (digit_valid),
    .digit_err   (digit_err),
    .word        (word),
    .word_valid  (word_valid),
    .word_err    (word_err)
  );

  always #5 clk = ~clk;

  // Error rule of the reference model: overflow or outside 3..12.
  function automatic logic model_err(input int d);
    return vs[d] || (codes[d] < 4'd3) || (codes[d] > 4'd12);
  endfunction

  // One clock edge with given inputs; returns at the following negedge.
  task automatic drive_edge(input logic s, input logic v);
    s_in = s;
    v_in = v;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; s_in = 1'b0; v_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (digit_valid !== 1'b0) begin n_bad++; $display("FAIL reset_dv got %b want 0", digit_valid); end
    n_cmp++; if (digit !== 4'h0) begin n_bad++; $display("FAIL reset_digit got %h want 0", digit); end
    n_cmp++; if (digit_err !== 1'b0) begin n_bad++; $display("FAIL reset_derr got %b want 0", digit_err); end
    n_cmp++; if (word_valid !== 1'b0) begin n_bad++; $display("FAIL reset_wv got %b want 0", word_valid); end
    n_cmp++; if (word !== '0) begin n_bad++; $display("FAIL reset_word got %h want 0", word); end
    n_cmp++; if (word_err !== 1'b0) begin n_bad++; $display("FAIL reset_werr got %b want 0", word_err); end
  endtask

  // Streams nd back-to-back digits from codes/vs right after reset and
  // checks every edge against the framing model (digit d appears at edge 4d+5).
  task automatic test_stream(input string name, input int nd);
    logic s, v, exp_dv, exp_wv, exp_werr;
    logic [4*NDIG-1:0] exp_word;
    int bi, d;
    do_reset();
    for (int n = 1; n <= 4*nd + 1; n++) begin
      bi = n - 1;
      d  = (n - 5) / 4;
      exp_dv = (n >= 5) && ((n - 5) % 4 == 0) && (d < nd);
      if (bi < 4*nd) s = codes[bi/4][bi%4];
      else           s = 1'($urandom_range(0, 1));
      if (exp_dv) v = vs[d];
      else        v = 1'($urandom_range(0, 1));
      drive_edge(s, v);
      n_cmp++;
      if (digit_valid !== exp_dv) begin
        n_bad++; $display("FAIL %s_dv edge=%0d got %b want %b", name, n, digit_valid, exp_dv);
      end
      if (exp_dv) begin
        n_cmp++;
        if (digit !== codes[d] || digit_err !== model_err(d)) begin
          n_bad++;
          $display("FAIL %s_digit edge=%0d got %h/%b want %h/%b", name, n, digit, digit_err, codes[d], model_err(d));
        end
      end
      exp_wv = exp_dv && (d % NDIG == NDIG - 1);
      n_cmp++;
      if (word_valid !== exp_wv) begin
        n_bad++; $display("FAIL %s_wv edge=%0d got %b want %b", name, n, word_valid, exp_wv);
      end
      if (exp_wv) begin
        exp_werr = 1'b0;
        for (int k = 0; k < NDIG; k++) begin
          exp_word[4*k +: 4] = codes[d - NDIG + 1 + k];
          exp_werr = exp_werr | model_err(d - NDIG + 1 + k);
        end
        n_cmp++;
        if (word !== exp_word || word_err !== exp_werr) begin
          n_bad++;
          $display("FAIL %s_word edge=%0d got %h/%b want %h/%b", name, n, word, word_err, exp_word, exp_werr);
        end
      end
    end
  endtask

  task automatic test_directed();
    logic [3:0] seq [0:15];
    seq = '{4'h4, 4'h5, 4'h6, 4'h7, 4'hD, 4'h3, 4'h4, 4'h5,
            4'h9, 4'hA, 4'hB, 4'hC, 4'h1, 4'h8, 4'h3, 4'hC};
    for (int i = 0; i < 16; i++) begin
      codes[i] = seq[i];
      vs[i]    = (i == 12);
    end
    test_stream("directed", 16);
  endtask

  task automatic test_random();
    for (int i = 0; i < 48; i++) begin
      codes[i] = 4'($urandom_range(0, 15));
      vs[i]    = ($urandom_range(0, 7) == 0);
    end
    test_stream("random", 48);
  endtask

  task automatic test_reset_mid_digit();
    logic [3:0] bits;
    do_reset();
    drive_edge(1'b1, 1'b0);
    drive_edge(1'b1, 1'b0);
    rst = 1'b1;
    drive_edge(1'b1, 1'b1);
    rst = 1'b0;
    // Digit 0,1,1,0 with v_in noise while nothing is pending.
    bits = 4'b0110;
    for (int n = 1; n <= 4; n++) begin
      drive_edge(bits[n-1], 1'b1);
      n_cmp++;
      if (digit_valid !== 1'b0) begin n_bad++; $display("FAIL partial_dv edge=%0d got %b want 0", n, digit_valid); end
    end
    // Edge 5 also carries bit 0 of code 5 (1,0,1,0).
    drive_edge(1'b1, 1'b0);
    n_cmp++;
    if (digit_valid !== 1'b1 || digit !== 4'h6 || digit_err !== 1'b0) begin
      n_bad++; $display("FAIL after_reset_digit got %b/%h/%b want 1/6/0", digit_valid, digit, digit_err);
    end
    drive_edge(1'b0, 1'b0);
    drive_edge(1'b1, 1'b0);
    drive_edge(1'b0, 1'b0);
    // Reset lands on the release edge of the pending digit.
    rst = 1'b1;
    drive_edge(1'b0, 1'b0);
    rst = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      drive_edge(1'b0, 1'b0);
      n_cmp++;
      if (digit_valid !== 1'b0 || digit !== 4'h0) begin
        n_bad++; $display("FAIL pending_reset edge=%0d got %b/%h want 0/0", n, digit_valid, digit);
      end
    end
  endtask

  task automatic test_reset_mid_word();
    logic [4*NDIG-1:0] exp_word;
    logic exp_werr;
    int bi;
    do_reset();
    for (int n = 1; n <= 9; n++) drive_edge(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    rst = 1'b1;
    drive_edge(1'b0, 1'b0);
    rst = 1'b0;
    exp_werr = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      codes[i] = 4'($urandom_range(0, 15));
      vs[i]    = 1'b0;
      exp_word[4*i +: 4] = codes[i];
      exp_werr = exp_werr | model_err(i);
    end
    for (int n = 1; n <= 4*NDIG + 1; n++) begin
      bi = n - 1;
      drive_edge((bi < 4*NDIG) ? codes[bi/4][bi%4] : 1'b0, 1'b0);
      n_cmp++;
      if (word_valid !== (n == 4*NDIG + 1)) begin
        n_bad++; $display("FAIL midword_wv edge=%0d got %b want %b", n, word_valid, (n == 4*NDIG + 1));
      end
    end
    n_cmp++;
    if (word !== exp_word || word_err !== exp_werr) begin
      n_bad++; $display("FAIL midword_word got %h/%b want %h/%b", word, word_err, exp_word, exp_werr);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset();
    test_random();
    test_reset_mid_digit();
    test_reset_mid_word();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/excess3_deserializer.md
Name: excess3_deserializer

Overview:
- Downstream consumer of the serial BCD-to-excess-3 converter.
- Samples the converter's serial output S (LSB first, 4 bits per digit) and its overflow flag V, and frames them into parallel 4-bit excess-3 digits.
- Flags invalid codes and packs NDIGITS consecutive digits into one parallel word for the display/register stage.

Parameters:
- NDIGITS, 4, digits per assembled word (≥2); word width is 4*NDIGITS.

Ports:
- clock  input  1  system clock; all state changes on posedge.
- reset  input  1  synchronous, active-high reset.
- s_in  input  1  serial excess-3 bit from converter S, LSB first.
- v_in  input  1  converter V flag; meaningful only in the phase-0 cycle following a digit's bit 3.
- digit  output  4  last completed excess-3 digit.
- digit_valid  output  1  one-cycle pulse when digit is updated.
- digit_err  output  1  error flag for digit, qualified by digit_valid.
- word  output  4*NDIGITS  assembled word; first-received digit in bits [3:0].
- word_valid  output  1  one-cycle pulse when word is updated.
- word_err  output  1  OR of digit_err over the digits of word, qualified by word_valid.

Behaviour:
- Synchronous active-high reset; clock and reset ports are named clock and reset.
- Reset clears to 0: phase counter, shift register, pending flag, digit counter, partial-word accumulator, and all outputs.
- Integration rule: reset is released on a digit boundary. The first posedge after reset deassertion samples bit 0 of a digit.
- Phase counter, 2 bits:
  - Increments every clock and wraps 3→0.
  - s_in is shifted in LSB first: shreg <= {s_in, shreg[3:1]}.
- On the edge where phase==3:
  - Completed 4-bit code (s_in plus shreg[3:1]) moves to a hold register.
  - Pending flag is set.
- On the next edge (phase==0), while pending:
  - digit <= hold; digit_valid <= 1.
  - digit_err <= v_in | (hold < 4'b0011) | (hold > 4'b1100).
  - Pending clears.
  - The same edge also shifts bit 0 of the following digit, so framing never stalls.
- Latency:
  - digit_valid asserts at the 5th posedge after reset release (bit 3 at edge 4).
  - Subsequent pulses occur every 4 clocks on back-to-back digits.
- digit_valid is a single-cycle pulse. digit and digit_err hold their value until the next pulse.
- Word assembly, on each digit_valid event:
  - acc <= {new_digit, acc[4*NDIGITS-1:4]}.
  - errAcc |= new_err.
  - Digit counter increments.
- When the counter reaches NDIGITS-1 and a digit event occurs, on the same edge as that digit's digit_valid:
  - word <= the fully shifted accumulator; word_err <= errAcc | new_err; word_valid <= 1.
  - Counter wraps to 0, errAcc clears, and the accumulator restarts.
- v_in is ignored whenever pending==0.
- Reset mid-digit or mid-word:
  - Partial bits and partial word are discarded; no valid pulses are emitted.
  - Framing restarts with bit 0 at the first edge after release.
- Reset asserted on the phase-0 edge with pending=1: reset wins, and no digit_valid is emitted.
- Code range: 3..12 (0011..1100) is the only legal excess-3 range. 0..2 and 13..15 set digit_err even if v_in=0.

Test Plan:
- Reset, then s_in bits 0,0,0,1 (excess-3 of 5), v_in=0 at edge 5 -> edge 5: digit_valid=1 for one cycle, digit=4'h8, digit_err=0.
- Four back-to-back digits with excess-3 codes 4,5,6,7 (BCD 1,2,3,4), NDIGITS=4:
  - digit_valid at edges 5,9,13,17.
  - Edge 17: word_valid=1, word=16'h7654, word_err=0.
- Code 1101 streamed with v_in=0 -> digit=4'hD, digit_err=1. The word containing it has word_err=1; the next word has word_err=0.
- Code 0001 with v_in=1 in the following phase-0 cycle -> digit=4'h1, digit_err=1. A v_in=1 pulse while pending=0 causes no error.
- Reset asserted after 2 bits of a digit, then released -> no digit_valid for the partial digit. The next full digit 0,1,1,0 yields digit=4'h6 at edge 5 after release.
- Reset after 2 of 4 digits of a word -> digit counter restarts. word_valid occurs only after 4 new digits, with word built solely from the new digits.
